// File: rtl/ysyx_22040759_ifu_axi_bridge_pkg.sv
// Shared definitions for the AXI4 read bridges (instruction side now, data side later).
package ysyx_22040759_ifu_axi_bridge_pkg;

  // Fixed AXI4 encodings used by single-beat 64-bit reads
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Read-channel FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } axi_rd_state_e;

  // Select the 32-bit word of a 64-bit beat addressed by address bit 2
  function automatic logic [31:0] pick_word(input logic hi, input logic [63:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040759_ifu_axi_bridge.sv
// IF-side AXI4 read master: one fetch request becomes one single-beat 64-bit read,
// and the addressed 32-bit instruction word is returned with a one-cycle if_ready.
module ysyx_22040759_ifu_axi_bridge
  import ysyx_22040759_ifu_axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [63:0]           inst_addr,
  output logic                  if_ready,
  output logic [63:0]           if_data_read,
  output logic                  if_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [AXI_ADDR_W-1:0] axi_araddr,
  output logic [AXI_ID_W-1:0]   axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [AXI_DATA_W-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [AXI_ID_W-1:0]   axi_rid
);

  // The word-select datapath assumes a 64-bit beat
  if (AXI_DATA_W != 64) begin : g_bad_data_w
    $error("ysyx_22040759_ifu_axi_bridge: AXI_DATA_W must be 64");
  end

  axi_rd_state_e           r_state;
  axi_rd_state_e           w_state_next;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_if_ready;
  logic                    r_if_err;
  logic [63:0]             r_data;
  logic [AXI_ADDR_W-1:0]   r_addr;
  logic                    w_arvalid_next;
  logic                    w_rready_next;
  logic                    w_if_ready_next;
  logic                    w_load;
  logic                    w_capture;
  logic                    w_unused;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: one outstanding read, AR then R then a single DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (if_valid)                 w_state_next = ST_AR;
      ST_AR:   if (r_arvalid && axi_arready) w_state_next = ST_R;
      ST_R:    if (r_rready && axi_rvalid)   w_state_next = ST_DONE;
      ST_DONE:                               w_state_next = ST_IDLE;
      default:                               w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: handshake outputs follow the state being entered so they are registered
  always_comb begin
    w_arvalid_next  = (w_state_next == ST_AR);
    w_rready_next   = (w_state_next == ST_R);
    w_if_ready_next = (w_state_next == ST_DONE);
    w_load          = (r_state == ST_IDLE) && if_valid;
    w_capture       = (r_state == ST_R) && r_rready && axi_rvalid;
  end

  // Output and datapath registers; address latched once so mid-flight changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_if_ready <= 1'b0;
      r_if_err   <= 1'b0;
      r_data     <= 64'h0;
      r_addr     <= '0;
    end else begin
      r_arvalid  <= w_arvalid_next;
      r_rready   <= w_rready_next;
      r_if_ready <= w_if_ready_next;
      if (w_load) r_addr <= inst_addr[AXI_ADDR_W-1:0];
      if (w_capture) begin
        r_data   <= {32'h0, pick_word(r_addr[2], axi_rdata)};
        r_if_err <= (axi_rresp != RESP_OKAY);
      end
    end
  end

  assign axi_arvalid  = r_arvalid;
  assign axi_rready   = r_rready;
  assign if_ready     = r_if_ready;
  assign if_err       = r_if_err;
  assign if_data_read = r_data;
  assign axi_araddr   = {r_addr[AXI_ADDR_W-1:3], 3'b000};
  assign axi_arid     = AXI_ID_W'(AXI_ID);
  assign axi_arlen    = 8'd0;
  assign axi_arsize   = SIZE_8B;
  assign axi_arburst  = BURST_INCR;

  // Bits with no hardware role: upper PC bits, byte offset, rlast (single beat)
  assign w_unused = ^{inst_addr, r_addr[1:0], axi_rlast};

  // Fetch addresses must be word aligned
  a_aligned: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_IDLE && if_valid) |-> (inst_addr[1:0] == 2'b00));

  // Returned beat should carry our ID; hardware does not depend on it
  a_rid: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_R && axi_rvalid) |-> (axi_rid == AXI_ID_W'(AXI_ID)));

endmodule

// File: tb/tb_ysyx_22040759_ifu_axi_bridge.sv
// Self-checking bench for the IF AXI read bridge: directed cases plus random fetches.
module tb_ysyx_22040759_ifu_axi_bridge;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [63:0] inst_addr;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic        if_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;

  int n_asserts = 0;
  int n_fail    = 0;

  ysyx_22040759_ifu_axi_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .inst_addr    (inst_addr),
    .if_ready     (if_ready),
    .if_data_read (if_data_read),
    .if_err       (if_err),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_araddr   (axi_araddr),
    .axi_arid     (axi_arid),
    .axi_arlen    (axi_arlen),
    .axi_arsize   (axi_arsize),
    .axi_arburst  (axi_arburst),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rlast    (axi_rlast),
    .axi_rid      (axi_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch, called at a negedge. chained: DUT is in its DONE cycle right now.
  // keep: leave if_valid high afterwards (next fetch follows back-to-back).
  task automatic fetch(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] resp,
                       input int aw, input int rw, input bit chained, input bit keep);
    int          lat, ar_cnt, r_cnt, exp_lat;
    bit          first_ar, ar_done, ar_ok;
    logic [31:0] ar_seen;
    logic [63:0] got_data, exp_data, exp_araddr;
    logic        got_err;
    lat = -1; ar_cnt = 0; r_cnt = 0;
    first_ar = 1; ar_done = 0; ar_ok = 1; ar_seen = '0;
    got_data = '0; got_err = 1'b0;
    inst_addr   = addr;
    if_valid    = 1'b1;
    axi_rdata   = data;
    axi_rresp   = resp;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (axi_arvalid) begin
        if (ar_done) ar_ok = 0;
        if (first_ar) begin ar_seen = axi_araddr; first_ar = 0; end
        else if (axi_araddr !== ar_seen) ar_ok = 0;
      end else if (!first_ar) begin
        ar_done = 1;
      end
      if (if_ready) begin
        lat = c; got_data = if_data_read; got_err = if_err;
      end
      // Slave: accept AR after aw wait cycles, return R after rw wait cycles
      if (axi_arvalid) begin ar_cnt++; axi_arready = (ar_cnt > aw); end
      else axi_arready = 1'b0;
      if (axi_rready) begin r_cnt++; axi_rvalid = (r_cnt > rw); end
      else axi_rvalid = 1'b0;
    end
    if_valid = keep;
    // Reference: araddr is the 8-byte aligned PC truncated to 32 bits; word picked by byte offset
    exp_lat    = 3 + aw + rw + (chained ? 1 : 0);
    exp_araddr = (addr & ~64'h7) & 64'hFFFF_FFFF;
    exp_data   = (data >> ((addr % 8) * 8)) & 64'hFFFF_FFFF;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("araddr", {32'h0, ar_seen}, exp_araddr);
    chk("ar_stable", {63'h0, ar_ok}, 64'h1);
    chk("if_data_read", got_data, exp_data);
    chk("if_err", {63'h0, got_err}, {63'h0, resp != 2'b00});
    if (!keep) begin
      @(negedge clk);
      chk("single_pulse", {63'h0, if_ready}, 64'h0);
      chk("idle_arvalid", {63'h0, axi_arvalid}, 64'h0);
    end
    $display("fetch addr=%h araddr=%h data=%h err=%0d lat=%0d (exp %0d)",
             addr, ar_seen, got_data, got_err, lat, exp_lat);
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1; if_valid = 1'b0; inst_addr = 64'h0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 64'h0;
    axi_rresp = 2'b00; axi_rlast = 1'b1; axi_rid = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arvalid", {63'h0, axi_arvalid}, 64'h0);
    chk("rst_rready", {63'h0, axi_rready}, 64'h0);
    chk("rst_if_ready", {63'h0, if_ready}, 64'h0);
    chk("rst_if_err", {63'h0, if_err}, 64'h0);
    chk("rst_data", if_data_read, 64'h0);
    chk("arlen", {56'h0, axi_arlen}, 64'h0);
    chk("arsize", {61'h0, axi_arsize}, 64'h3);
    chk("arburst", {62'h0, axi_arburst}, 64'h1);
    chk("arid", {60'h0, axi_arid}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: lower word, upper word, wait states, error response
    fetch(64'h8000_0000, 64'h00100093_00000413, 2'b00, 0, 0, 0, 0);
    fetch(64'h8000_0004, 64'h00100093_00000413, 2'b00, 0, 0, 0, 0);
    fetch(64'h8000_0000, 64'h00100093_00000413, 2'b00, 5, 3, 0, 0);
    fetch(64'h8000_0008, 64'hDEADBEEF_CAFEF00D, 2'b10, 0, 0, 0, 0);

    // Back-to-back: IF advances PC by 4 on each completion
    fetch(64'h8000_0000, 64'h11111111_22222222, 2'b00, 0, 0, 0, 1);
    fetch(64'h8000_0004, 64'h33333333_44444444, 2'b00, 0, 0, 1, 1);
    fetch(64'h8000_0008, 64'h55555555_66666666, 2'b00, 0, 0, 1, 1);
    fetch(64'h8000_000C, 64'h77777777_88888888, 2'b00, 0, 0, 1, 0);

    // Reset while in R
    inst_addr = 64'h8000_0010; if_valid = 1'b1; axi_arready = 1'b1; axi_rvalid = 1'b0;
    @(negedge clk);
    chk("mr_arvalid", {63'h0, axi_arvalid}, 64'h1);
    @(negedge clk);
    chk("mr_rready", {63'h0, axi_rready}, 64'h1);
    rst = 1'b1; if_valid = 1'b0; axi_arready = 1'b0;
    @(negedge clk);
    chk("mr_arvalid_rst", {63'h0, axi_arvalid}, 64'h0);
    chk("mr_rready_rst", {63'h0, axi_rready}, 64'h0);
    chk("mr_if_ready_rst", {63'h0, if_ready}, 64'h0);
    chk("mr_data_rst", if_data_read, 64'h0);
    rst = 1'b0;
    fetch(64'h8000_0014, 64'hA5A5A5A5_5A5A5A5A, 2'b00, 0, 0, 0, 0);

    // Random fetches, including nonzero upper PC bits (truncated on araddr)
    for (int i = 0; i < 20; i++) begin
      a = {32'($urandom_range(0, 3)), 32'h8000_0000 + 32'($urandom_range(0, 1023) << 2)};
      fetch(a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
